// File: rtl/big_core_dmem_responder.sv
// big_core_dmem_responder
//
// Data-memory access unit for the big_core pipeline. Captures Q103H load/store
// requests, issues them on the data-memory fabric with a valid/ready handshake,
// collects read responses and formats them into LoadDataQ105H. ReadyQ105H is
// the global pipeline advance enable and is high only while the FSM is idle.
//
// Ports:
//   Clock, Rst                 core clock, asynchronous active-high reset
//   CtrlDMemRdEnQ103H/WrEn     load / store request (both high = store)
//   CtrlLsSizeQ103H            0 byte, 1 half, 2/3 word
//   CtrlSignExtQ103H           sign-extend load data
//   DMemAddressQ103H           byte address
//   DMemWrDataQ103H            right-justified store data
//   FabReq*                    fabric request channel (valid/ready)
//   FabRspValid, FabRspData    fabric read response
//   ReadyQ105H                 pipeline advance enable
//   LoadDataQ105H              formatted load result
//   MisalignErr, TimeoutErr    sticky error flags

module big_core_dmem_responder #(
  parameter int unsigned RSP_TIMEOUT = 256
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        CtrlDMemRdEnQ103H,
  input  logic        CtrlDMemWrEnQ103H,
  input  logic [1:0]  CtrlLsSizeQ103H,
  input  logic        CtrlSignExtQ103H,
  input  logic [31:0] DMemAddressQ103H,
  input  logic [31:0] DMemWrDataQ103H,
  output logic        FabReqValid,
  input  logic        FabReqReady,
  output logic        FabReqWr,
  output logic [31:0] FabReqAddress,
  output logic [31:0] FabReqData,
  output logic [3:0]  FabReqByteEn,
  input  logic        FabRspValid,
  input  logic [31:0] FabRspData,
  output logic        ReadyQ105H,
  output logic [31:0] LoadDataQ105H,
  output logic        MisalignErr,
  output logic        TimeoutErr
);

  localparam int unsigned CntW = ($clog2(RSP_TIMEOUT) > 8) ? $clog2(RSP_TIMEOUT) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     load_q, load_d;
  logic            misalign_q, misalign_d;
  logic            timeout_q, timeout_d;

  // Captured request
  logic        wr_q;
  logic [31:0] addr_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;

  logic        req_any;
  logic        aligned;
  logic        capture;
  logic [1:0]  size_norm;
  logic [3:0]  be_new;
  logic [31:0] data_new;
  logic [31:0] rsp_shift;
  logic [15:0] rsp_half;
  logic [31:0] load_fmt;

  assign req_any   = CtrlDMemRdEnQ103H | CtrlDMemWrEnQ103H;
  assign size_norm = (CtrlLsSizeQ103H == 2'd3) ? 2'd2 : CtrlLsSizeQ103H;

  always_comb begin
    aligned  = 1'b1;
    be_new   = 4'b1111;
    data_new = DMemWrDataQ103H;
    unique case (size_norm)
      2'd0: begin
        be_new   = 4'b0001 << DMemAddressQ103H[1:0];
        data_new = {4{DMemWrDataQ103H[7:0]}};
      end
      2'd1: begin
        aligned  = ~DMemAddressQ103H[0];
        be_new   = 4'b0011 << DMemAddressQ103H[1:0];
        data_new = {2{DMemWrDataQ103H[15:0]}};
      end
      default: begin
        aligned = ~|DMemAddressQ103H[1:0];
      end
    endcase
  end

  // Load formatting from the captured lane/size/extension
  assign rsp_shift = FabRspData >> {lane_q, 3'b000};
  assign rsp_half  = lane_q[1] ? FabRspData[31:16] : FabRspData[15:0];

  always_comb begin
    load_fmt = FabRspData;
    unique case (size_q)
      2'd0:    load_fmt = {{24{sext_q & rsp_shift[7]}}, rsp_shift[7:0]};
      2'd1:    load_fmt = {{16{sext_q & rsp_half[15]}}, rsp_half};
      default: load_fmt = FabRspData;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_d     = load_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          if (aligned) begin
            capture = 1'b1;
            state_d = StReq;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (FabReqReady) begin
          if (wr_q) begin
            state_d = StIdle;
          end else begin
            state_d = StWaitRsp;
            cnt_d   = '0;
          end
        end
      end
      StWaitRsp: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the final cycle still beats the timeout.
        if (FabRspValid) begin
          load_d  = load_fmt;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          load_d    = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      load_q     <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      lane_q <= '0;
      size_q <= '0;
      sext_q <= 1'b0;
      data_q <= '0;
      be_q   <= '0;
    end else if (capture) begin
      wr_q   <= CtrlDMemWrEnQ103H;
      addr_q <= {DMemAddressQ103H[31:2], 2'b00};
      lane_q <= DMemAddressQ103H[1:0];
      size_q <= size_norm;
      sext_q <= CtrlSignExtQ103H;
      data_q <= data_new;
      be_q   <= be_new;
    end
  end

  assign ReadyQ105H    = (state_q == StIdle);
  assign FabReqValid   = (state_q == StReq);
  assign FabReqWr      = wr_q;
  assign FabReqAddress = addr_q;
  assign FabReqData    = data_q;
  assign FabReqByteEn  = be_q;
  assign LoadDataQ105H = load_q;
  assign MisalignErr   = misalign_q;
  assign TimeoutErr    = timeout_q;

endmodule

// File: tb/tb_big_core_dmem_responder.sv
module tb_big_core_dmem_responder;

  localparam int unsigned Tmo = 16;

  logic        Clock = 1'b0;
  logic        Rst;
  logic        rd_en, wr_en, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        ready;
  logic [31:0] load_data;
  logic        mis_err, tmo_err;

  int total = 0;
  int bad   = 0;
  int n;

  big_core_dmem_responder #(.RSP_TIMEOUT(Tmo)) dut (
    .Clock             (Clock),
    .Rst               (Rst),
    .CtrlDMemRdEnQ103H (rd_en),
    .CtrlDMemWrEnQ103H (wr_en),
    .CtrlLsSizeQ103H   (size),
    .CtrlSignExtQ103H  (sext),
    .DMemAddressQ103H  (addr),
    .DMemWrDataQ103H   (wdata),
    .FabReqValid       (req_valid),
    .FabReqReady       (req_ready),
    .FabReqWr          (req_wr),
    .FabReqAddress     (req_addr),
    .FabReqData        (req_data),
    .FabReqByteEn      (req_be),
    .FabRspValid       (rsp_valid),
    .FabRspData        (rsp_data),
    .ReadyQ105H        (ready),
    .LoadDataQ105H     (load_data),
    .MisalignErr       (mis_err),
    .TimeoutErr        (tmo_err)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one capture edge, then drop the enables.
  task automatic issue(input logic r, input logic w, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d);
    rd_en = r; wr_en = w; size = s; sext = se; addr = a; wdata = d;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    rd_en = 0; wr_en = 0; size = 0; sext = 0; addr = 0; wdata = 0;
    req_ready = 0; rsp_valid = 0; rsp_data = 0;
    tick(); tick();
    check("rst_ready", ready, 1);
    check("rst_valid", req_valid, 0);
    check("rst_wr", req_wr, 0);
    check("rst_addr", req_addr, 0);
    check("rst_data", req_data, 0);
    check("rst_be", req_be, 0);
    check("rst_load", load_data, 0);
    check("rst_mis", mis_err, 0);
    check("rst_tmo", tmo_err, 0);
    Rst = 1'b0;
    tick();

    // Store byte at 0x1003
    req_ready = 1'b1;
    issue(0, 1, 2'd0, 0, 32'h0000_1003, 32'h0000_00AB);
    check("sb_valid", req_valid, 1);
    check("sb_wr", req_wr, 1);
    check("sb_be", req_be, 4'b1000);
    check("sb_data", req_data, 32'hABAB_ABAB);
    check("sb_addr", req_addr, 32'h0000_1000);
    check("sb_stall", ready, 0);
    tick();
    check("sb_done_ready", ready, 1);
    check("sb_done_valid", req_valid, 0);

    // Load byte, sign-extended, at 0x2002 (store and load issued back-to-back)
    issue(1, 0, 2'd0, 1, 32'h0000_2002, 32'h0);
    check("lb_valid", req_valid, 1);
    check("lb_wr", req_wr, 0);
    check("lb_be", req_be, 4'b0100);
    check("lb_stall1", ready, 0);
    tick();
    check("lb_wait_valid", req_valid, 0);
    check("lb_stall2", ready, 0);
    rsp_valid = 1'b1; rsp_data = 32'h00F1_0000;
    tick();
    rsp_valid = 1'b0;
    check("lb_ready", ready, 1);
    check("lb_data", load_data, 32'hFFFF_FFF1);
    tick();
    check("lb_hold", load_data, 32'hFFFF_FFF1);

    // Load half, zero-extended, at 0x2002
    issue(1, 0, 2'd1, 0, 32'h0000_2002, 32'h0);
    check("lh_be", req_be, 4'b1100);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h8001_0000;
    tick();
    rsp_valid = 1'b0;
    check("lh_data", load_data, 32'h0000_8001);

    // Word load with 3 cycles of backpressure
    req_ready = 1'b0;
    issue(1, 0, 2'd2, 0, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_ready = 1'b1;
      check("bp_valid", req_valid, 1);
      check("bp_addr", req_addr, 32'h0000_4000);
      check("bp_be", req_be, 4'b1111);
      check("bp_wr", req_wr, 0);
      check("bp_stall", ready, 0);
      tick();
    end
    check("bp_wait_valid", req_valid, 0);
    tick();
    check("bp_wait_stall", ready, 0);
    rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
    tick();
    rsp_valid = 1'b0;
    check("bp_ready", ready, 1);
    check("bp_data", load_data, 32'h1234_5678);

    // Misaligned half store: no request, no stall, load data untouched
    issue(0, 1, 2'd1, 0, 32'h0000_3001, 32'h0000_BEEF);
    check("mis_valid", req_valid, 0);
    check("mis_err", mis_err, 1);
    check("mis_ready", ready, 1);
    check("mis_load", load_data, 32'h1234_5678);

    // Stray response in idle is ignored
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    check("stray_load", load_data, 32'h1234_5678);
    check("stray_ready", ready, 1);

    // Load with no response -> timeout after Tmo wait cycles
    issue(1, 0, 2'd2, 0, 32'h0000_5000, 32'h0);
    tick();
    check("tmo_pre", tmo_err, 0);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, Tmo);
    check("tmo_err", tmo_err, 1);
    check("tmo_load", load_data, 0);
    check("tmo_ready", ready, 1);

    // Response on the last wait cycle beats the timeout
    issue(1, 0, 2'd2, 0, 32'h0000_6000, 32'h0);
    tick();
    for (int i = 0; i < Tmo - 1; i++) tick();
    check("edge_stall", ready, 0);
    rsp_valid = 1'b1; rsp_data = 32'hCAFE_F00D;
    tick();
    rsp_valid = 1'b0;
    check("edge_load", load_data, 32'hCAFE_F00D);

    // Reset in the middle of a read
    issue(1, 0, 2'd2, 0, 32'h0000_7000, 32'h0);
    tick();
    check("mid_wait", ready, 0);
    Rst = 1'b1;
    #1;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_valid", req_valid, 0);
    check("mid_rst_load", load_data, 0);
    check("mid_rst_tmo", tmo_err, 0);
    tick();
    Rst = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    tick();
    rsp_valid = 1'b0;
    check("post_rst_load", load_data, 0);
    check("post_rst_ready", ready, 1);
    check("post_rst_valid", req_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
